// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Holds the FSM state encoding, the board type and the eight winning-line masks.
package ttt_pkg;

  typedef enum logic [1:0] {IDLE, TURN, CHECK, DONE} ttt_state_t;

  localparam int NUM_CELLS = 9;

  typedef logic [NUM_CELLS-1:0] board_t;

  // Rows, columns, then the two diagonals; bit i = cell i, row-major.
  localparam logic [8:0] WIN_LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

endpackage

// File: rtl/ttt_line_detect.sv
// Combinational three-in-a-line detector for one player's board.
module ttt_line_detect
  import ttt_pkg::*;
(
  input  board_t board_i,
  output logic   line_o
);

  always_comb begin
    line_o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board_i & WIN_LINES[i]) == WIN_LINES[i]) line_o = 1'b1;
    end
  end

endmodule

// File: rtl/tic_tac_toe_game_ctrl.sv
// Tic-tac-toe game controller: board registers, turn sequencing, move handshake, win/draw.
// Optional per-turn forfeit timer enabled with `define TTT_MOVE_TIMEOUT_EN.
module tic_tac_toe_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER   = 1'b0,
  parameter int   TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn_o,
  output logic       illegal,
  output logic       win_x,
  output logic       win_o,
  output logic       draw,
`ifdef TTT_MOVE_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic       game_over
);

  ttt_state_t state_q;
  board_t     board_x_q, board_o_q;
  logic       turn_q;
  logic       illegal_q;
  logic       win_x_q, win_o_q, draw_q;

  board_t     occ;
  board_t     pos_mask;
  board_t     board_x_d, board_o_d;
  logic       accept;
  logic       line_x, line_o;
  logic       mover_win;

  assign occ      = board_x_q | board_o_q;
  assign pos_mask = (move_pos <= 4'd8) ? (board_t'(1) << move_pos) : '0;
  // A zero mask marks an out-of-range position, so it can never be accepted.
  assign accept   = (state_q == TURN) && move_valid && (pos_mask != '0)
                    && ((occ & pos_mask) == '0);

  assign board_x_d = turn_q ? board_x_q : (board_x_q | pos_mask);
  assign board_o_d = turn_q ? (board_o_q | pos_mask) : board_o_q;

  ttt_line_detect u_line_x (
    .board_i (board_x_q),
    .line_o  (line_x)
  );

  ttt_line_detect u_line_o (
    .board_i (board_o_q),
    .line_o  (line_o)
  );

  // Only the player who just moved can have completed a line.
  assign mover_win = turn_q ? line_o : line_x;

`ifdef TTT_MOVE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      board_x_q <= '0;
      board_o_q <= '0;
      turn_q    <= FIRST_PLAYER;
      illegal_q <= 1'b0;
      win_x_q   <= 1'b0;
      win_o_q   <= 1'b0;
      draw_q    <= 1'b0;
`ifdef TTT_MOVE_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      illegal_q <= 1'b0;
      if (start) begin
        state_q   <= TURN;
        board_x_q <= '0;
        board_o_q <= '0;
        turn_q    <= FIRST_PLAYER;
        win_x_q   <= 1'b0;
        win_o_q   <= 1'b0;
        draw_q    <= 1'b0;
`ifdef TTT_MOVE_TIMEOUT_EN
        cnt_q     <= '0;
        timeout_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          TURN: begin
            if (accept) begin
              board_x_q <= board_x_d;
              board_o_q <= board_o_d;
              state_q   <= CHECK;
            end else begin
              if (move_valid) illegal_q <= 1'b1;
`ifdef TTT_MOVE_TIMEOUT_EN
              // Illegal offers keep the clock running; only a fresh turn restarts it.
              if (cnt_q == CNT_LAST) begin
                timeout_q <= 1'b1;
                win_x_q   <= turn_q;
                win_o_q   <= ~turn_q;
                state_q   <= DONE;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
`endif
            end
          end
          CHECK: begin
            if (mover_win) begin
              win_x_q <= ~turn_q;
              win_o_q <= turn_q;
              state_q <= DONE;
            end else if (&occ) begin
              draw_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= TURN;
`ifdef TTT_MOVE_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign move_ready = (state_q == TURN);
  assign board_x    = board_x_q;
  assign board_o    = board_o_q;
  assign turn_o     = turn_q;
  assign illegal    = illegal_q;
  assign win_x      = win_x_q;
  assign win_o      = win_o_q;
  assign draw       = draw_q;
`ifdef TTT_MOVE_TIMEOUT_EN
  assign timeout    = timeout_q;
  assign game_over  = win_x_q | win_o_q | draw_q | timeout_q;
`else
  assign game_over  = win_x_q | win_o_q | draw_q;
`endif

endmodule

// File: tb/tb_tic_tac_toe_game_ctrl.sv
// Self-checking bench for tic_tac_toe_game_ctrl: directed games plus random games against a cell-array model.
module tb_tic_tac_toe_game_ctrl;
  import ttt_pkg::*;

  localparam logic FIRST = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = '0;
  logic       move_ready;
  logic [8:0] board_x, board_o;
  logic       turn_o, illegal, win_x, win_o, draw, game_over;
`ifdef TTT_MOVE_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clk = ~clk;

`ifdef TTT_MOVE_TIMEOUT_EN
  tic_tac_toe_game_ctrl #(.FIRST_PLAYER(FIRST), .TIMEOUT_CYCLES(16)) dut (
`else
  tic_tac_toe_game_ctrl #(.FIRST_PLAYER(FIRST)) dut (
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .move_ready (move_ready),
    .board_x    (board_x),
    .board_o    (board_o),
    .turn_o     (turn_o),
    .illegal    (illegal),
    .win_x      (win_x),
    .win_o      (win_o),
    .draw       (draw),
`ifdef TTT_MOVE_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .game_over  (game_over)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 empty, 1 X, 2 O
  int cells [9];
  bit m_turn, m_wx, m_wo, m_draw, m_ready;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] board_of(input int p);
    logic [8:0] b = '0;
    for (int i = 0; i < 9; i++) if (cells[i] == p) b[i] = 1'b1;
    return b;
  endfunction

  function automatic bit has_line(input int p);
    bit w = 0;
    for (int k = 0; k < 3; k++) begin
      if (cells[3*k] == p && cells[3*k+1] == p && cells[3*k+2] == p) w = 1;
      if (cells[k] == p && cells[k+3] == p && cells[k+6] == p) w = 1;
    end
    if (cells[0] == p && cells[4] == p && cells[8] == p) w = 1;
    if (cells[2] == p && cells[4] == p && cells[6] == p) w = 1;
    return w;
  endfunction

  function automatic bit board_full();
    bit f = 1;
    for (int i = 0; i < 9; i++) if (cells[i] == 0) f = 0;
    return f;
  endfunction

  task automatic model_clear(input bit ready);
    for (int i = 0; i < 9; i++) cells[i] = 0;
    m_turn = FIRST; m_wx = 0; m_wo = 0; m_draw = 0; m_ready = ready;
  endtask

  task automatic check_all(input string tag);
    chk_val({tag, ".bx"}, board_x, board_of(1));
    chk_val({tag, ".bo"}, board_o, board_of(2));
    chk_val({tag, ".turn"}, turn_o, m_turn);
    chk_val({tag, ".wx"}, win_x, m_wx);
    chk_val({tag, ".wo"}, win_o, m_wo);
    chk_val({tag, ".draw"}, draw, m_draw);
    chk_val({tag, ".over"}, game_over, m_wx | m_wo | m_draw);
    chk_val({tag, ".ready"}, move_ready, m_ready);
`ifdef TTT_MOVE_TIMEOUT_EN
    chk_val({tag, ".tmo"}, timeout, 1'b0);
`endif
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
    model_clear(1);
    check_all("start");
  endtask

  task automatic do_move(input int pos);
    bit legal;
    chk_val("pre.ready", move_ready, m_ready);
    move_valid = 1; move_pos = pos[3:0];
    tick();
    move_valid = 0;
    if (!m_ready) begin
      chk_val("ign.illegal", illegal, 1'b0);
      check_all("ign");
      return;
    end
    legal = (pos <= 8) && (cells[pos] == 0);
    if (!legal) begin
      chk_val("rej.illegal", illegal, 1'b1);
      check_all("rej");
      tick();
      chk_val("rej.clear", illegal, 1'b0);
      return;
    end
    cells[pos] = m_turn ? 2 : 1;
    chk_val("acc.illegal", illegal, 1'b0);
    chk_val("acc.bx", board_x, board_of(1));
    chk_val("acc.bo", board_o, board_of(2));
    chk_val("acc.ready", move_ready, 1'b0);
    chk_val("acc.over", game_over, 1'b0);
    tick();
    if (has_line(m_turn ? 2 : 1)) begin
      if (m_turn) m_wo = 1; else m_wx = 1;
      m_ready = 0;
    end else if (board_full()) begin
      m_draw = 1; m_ready = 0;
    end else begin
      m_turn = ~m_turn;
    end
    check_all("res");
  endtask

  task automatic play(input int seq []);
    foreach (seq[i]) do_move(seq[i]);
  endtask

  initial begin
    model_clear(0);
    rst_n = 0; tick(); tick(); rst_n = 1;
    check_all("reset");

    // Row 0 win for X
    do_start();
    play('{0, 3, 1, 4, 2});
    chk_val("t1.bx", board_x, 9'h007);
    chk_val("t1.bo", board_o, 9'h018);
    chk_val("t1.wx", win_x, 1'b1);
    do_move(5);

    // Occupied and out-of-range offers
    do_start();
    play('{4, 4, 9, 15, 0});

    // Draw, then win on the ninth move
    do_start();
    play('{0, 1, 2, 4, 3, 5, 7, 6, 8});
    chk_val("t3.draw", draw, 1'b1);
    do_start();
    play('{0, 1, 2, 4, 3, 5, 7, 8, 6});
    chk_val("t4.wx", win_x, 1'b1);
    chk_val("t4.draw", draw, 1'b0);

    // Mid-game reset, then start arriving during CHECK
    do_start();
    play('{0, 3});
    rst_n = 0; tick(); rst_n = 1;
    model_clear(0);
    check_all("midrst");
    do_start();
    play('{4});
    move_valid = 1; move_pos = 4'd8; tick();
    move_valid = 0; start = 1; tick(); start = 0;
    model_clear(1);
    check_all("chkstart");

`ifdef TTT_MOVE_TIMEOUT_EN
    do_start();
    for (int i = 0; i < 15; i++) tick();
    chk_val("tmo.ready15", move_ready, 1'b1);
    tick();
    chk_val("tmo.flag", timeout, 1'b1);
    chk_val("tmo.wo", win_o, 1'b1);
    chk_val("tmo.wx", win_x, 1'b0);
    chk_val("tmo.ready", move_ready, 1'b0);
    chk_val("tmo.over", game_over, 1'b1);
`endif

    // Random games with occasional illegal offers and mid-game restarts
    for (int g = 0; g < 40; g++) begin
      do_start();
      while (m_ready) begin
        int p;
        if ($urandom_range(0, 3) == 0) begin
          p = $urandom_range(0, 15);
          if (p <= 8 && cells[p] == 0) p = 9 + $urandom_range(0, 6);
          do_move(p);
        end
        if ($urandom_range(0, 29) == 0) break;
        do begin
          p = $urandom_range(0, 8);
        end while (cells[p] != 0);
        do_move(p);
      end
      if (!m_ready) do_move($urandom_range(0, 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
